dwncnt_tick_gen: RTL and testbench

//  Upstream enable generator for the 4-bit down-counter stage. Divides clk by a programmable

---
 rtl/tickgen_pkg.sv | 14 +
 rtl/dwncnt_tick_prescaler.sv | 29 ++
 rtl/dwncnt_tick_gen.sv | 103 ++++++++++
 tb/tb_dwncnt_tick_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tickgen_pkg.sv
// Shared definitions for the down-counter tick generator:
// FSM state encoding and default widths.
package tickgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tick_state_t;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/dwncnt_tick_prescaler.sv
// Programmable prescaler: load, hold, decrement, reload-on-zero.
// zero flags the cycle on which the next step issues a tick.
module dwncnt_tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_val,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            cnt <= (cnt == '0) ? reload_val : cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dwncnt_tick_gen.sv
// Enable-tick generator for the 4-bit down-counter stage.
// Optional pause input when DWNCNT_TICK_GEN_PAUSE_EN is defined.
module dwncnt_tick_gen
    import tickgen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef DWNCNT_TICK_GEN_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] n_ticks,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rem
);

    tick_state_t      state;
    logic [DIV_W-1:0] div_l;
    logic             pre_zero;
    logic             hold;
    logic             accept;
    logic             step;

`ifdef DWNCNT_TICK_GEN_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign accept = (state == IDLE) && start;
    assign step   = (state == RUN) && !stop && !hold;

    dwncnt_tick_prescaler #(
        .DIV_W(DIV_W)
    ) u_pre (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (step),
        .load_val  (div_val),
        .reload_val(div_l),
        .zero      (pre_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div_l <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rem   <= '0;
        end else begin
            en   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        div_l <= div_val;
                        rem   <= n_ticks;
                        if (n_ticks != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    // stop beats both pause and a pulse due this edge
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!hold && pre_zero) begin
                        en  <= 1'b1;
                        rem <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    rem   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dwncnt_tick_gen.sv
// Self-checking bench for dwncnt_tick_gen: vector table, hand
// sequences and randomized runs against an arithmetic run model.
module tb_dwncnt_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] div_val;
    logic [3:0] n_ticks;
    logic       en;
    logic       busy;
    logic       done;
    logic [3:0] rem;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dwncnt_tick_gen dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
`ifdef DWNCNT_TICK_GEN_PAUSE_EN
        .pause  (pause),
`endif
        .div_val(div_val),
        .n_ticks(n_ticks),
        .en     (en),
        .busy   (busy),
        .done   (done),
        .rem    (rem)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] div_val;
        logic [3:0] n_ticks;
        logic       en;
        logic       busy;
        logic       done;
        logic [3:0] rem;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    task automatic chk_all(input string tag, input logic e_en,
                           input logic e_busy, input logic e_done,
                           input logic [3:0] e_rem);
        chk({tag, ".en"}, int'(en), int'(e_en));
        chk({tag, ".busy"}, int'(busy), int'(e_busy));
        chk({tag, ".done"}, int'(done), int'(e_done));
        chk({tag, ".rem"}, int'(rem), int'(e_rem));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic p,
                                input int d, input int n, input logic e,
                                input logic b, input logic dn, input int r);
        vec_t v;
        v.start   = s;
        v.stop    = p;
        v.div_val = 8'(d);
        v.n_ticks = 4'(n);
        v.en      = e;
        v.busy    = b;
        v.done    = dn;
        v.rem     = 4'(r);
        return v;
    endfunction

    // Model of one run started at edge 0, observed just after edge t.
    // stop_at = 0 means the run is never aborted.
    task automatic model(input int d, input int n, input int stop_at,
                         input int t, output logic e, output logic b,
                         output logic dn, output logic [3:0] r);
        int per;
        int k;
        per = d + 1;
        if (stop_at != 0 && t >= stop_at) begin
            e  = 1'b0;
            b  = 1'b0;
            dn = 1'b0;
            r  = 4'(n - (stop_at - 1) / per);
        end else begin
            k  = t / per;
            e  = (t >= 1) && (t % per == 0) && (k <= n);
            b  = (t < n * per);
            dn = (t == n * per + 1);
            r  = (k >= n) ? 4'd0 : 4'(n - k);
        end
    endtask

    task automatic run_case(input int d, input int n, input int stop_at,
                            input bit noise);
        int   last;
        int   span;
        logic e, b, dn;
        logic [3:0] r;
        span = n * (d + 1);
        last = (stop_at != 0) ? stop_at + 2 : span + 3;
        for (int t = 0; t <= last; t++) begin
            if (t == 0) begin
                start   = 1'b1;
                stop    = noise ? 1'($urandom_range(1)) : 1'b0;
                div_val = 8'(d);
                n_ticks = 4'(n);
            end else begin
                if (noise) begin
                    div_val = 8'($urandom);
                    n_ticks = 4'($urandom);
                end
                if (stop_at != 0) start = noise && t < stop_at
                                          && 1'($urandom_range(1));
                else start = noise && t <= span + 1
                             && 1'($urandom_range(1));
                if (t == stop_at) stop = 1'b1;
                else if (stop_at == 0 && t > span && noise)
                    stop = 1'($urandom_range(1));
                else stop = 1'b0;
            end
            tick();
            model(d, n, stop_at, t, e, b, dn, r);
            chk_all($sformatf("run d%0d n%0d s%0d t%0d", d, n, stop_at, t),
                    e, b, dn, r);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int d, n, s;
        int cnt;
        rst     = 1'b1;
        start   = 1'b1;
        stop    = 1'b0;
        pause   = 1'b0;
        div_val = 8'd3;
        n_ticks = 4'd4;

        // reset dominates a held start
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_all("post_reset", 1'b0, 1'b0, 1'b0, 4'd0);

        vecs[0]  = mk(1, 0, 0, 5, 0, 1, 0, 5);
        vecs[1]  = mk(0, 0, 7, 2, 1, 1, 0, 4);
        vecs[2]  = mk(0, 0, 7, 2, 1, 1, 0, 3);
        vecs[3]  = mk(0, 0, 7, 2, 1, 1, 0, 2);
        vecs[4]  = mk(0, 0, 7, 2, 1, 1, 0, 1);
        vecs[5]  = mk(0, 0, 7, 2, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 7, 2, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 7, 2, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 9, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 9, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 9, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 1, 1, 2, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 1, 2, 0, 1, 0, 2);
        vecs[14] = mk(0, 0, 1, 2, 1, 1, 0, 1);
        vecs[15] = mk(0, 0, 1, 2, 0, 1, 0, 1);
        vecs[16] = mk(0, 0, 1, 2, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 2, 0, 0, 1, 0);
        for (int i = 0; i < 18; i++) begin
            start   = vecs[i].start;
            stop    = vecs[i].stop;
            div_val = vecs[i].div_val;
            n_ticks = vecs[i].n_ticks;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].busy,
                    vecs[i].done, vecs[i].rem);
        end
        start = 1'b0;
        tick();

        run_case(3, 4, 0, 1'b0);
        run_case(2, 6, 7, 1'b0);
        run_case(2, 6, 9, 1'b0);

        // reset in the middle of a run
        start   = 1'b1;
        div_val = 8'd5;
        n_ticks = 4'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("midrun.busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk_all("midrun_rst", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(en) + int'(done) + int'(busy);
        end
        chk("midrun.quiet", cnt, 0);
        run_case(5, 9, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(7);
            n = $urandom_range(15);
            s = 0;
            if (n != 0 && $urandom_range(1) == 1)
                s = $urandom_range(n * (d + 1), 1);
            run_case(d, n, s, 1'b1);
        end

`ifdef DWNCNT_TICK_GEN_PAUSE_EN
        // pulses expected at edges 2, 8, 10 and done at 11
        start   = 1'b1;
        div_val = 8'd1;
        n_ticks = 4'd3;
        cnt     = 0;
        for (int t = 0; t <= 13; t++) begin
            if (t > 0) start = 1'b0;
            pause = (t >= 3 && t <= 6);
            tick();
            cnt += int'(en);
            chk($sformatf("pause.en t%0d", t), int'(en),
                int'(t == 2 || t == 8 || t == 10));
            chk($sformatf("pause.busy t%0d", t), int'(busy),
                int'(t < 10));
            chk($sformatf("pause.done t%0d", t), int'(done),
                int'(t == 11));
        end
        pause = 1'b0;
        chk("pause.count", cnt, 3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
